// File: rtl/div_if.sv
// Handshake and result bus between the EX-stage control and the divider.
interface div_if #(
   parameter int unsigned DATA_W = 32
);
   logic              start;
   logic              annul;
   logic              signed_div;
   logic [DATA_W-1:0] dividend;
   logic [DATA_W-1:0] divisor;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] quotient;
   logic [DATA_W-1:0] remainder;

   modport master (
      output start, annul, signed_div, dividend, divisor,
      input  busy, done, quotient, remainder
   );

   modport slave (
      input  start, annul, signed_div, dividend, divisor,
      output busy, done, quotient, remainder
   );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU): quotient to LO, remainder to HI.
// Operands are reduced to magnitudes at acceptance; signs are applied on the final edge.
module div_unit #(
   parameter int unsigned DATA_W = 32
) (
   input  logic  clk,
   input  logic  resetn,
   div_if.slave  bus
);
   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVZERO,
      S_ON,
      S_END
   } state_t;

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] quotient_q, quotient_d;
   logic [DATA_W-1:0] remainder_q, remainder_d;
   logic [DATA_W-1:0] part_q, part_d;      // partial remainder
   logic [DATA_W-1:0] dvd_q, dvd_d;        // dividend bits shifting out, quotient bits shifting in
   logic [DATA_W-1:0] dsr_q, dsr_d;        // divisor magnitude
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;

   logic [DATA_W:0]   shifted_c;
   logic [DATA_W:0]   diff_c;
   logic              borrow_c;
   logic [DATA_W-1:0] dd_abs_c;
   logic [DATA_W-1:0] ds_abs_c;

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;

   // Next-state, datapath step and result formatting.
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      part_d      = part_q;
      dvd_d       = dvd_q;
      dsr_d       = dsr_q;
      cnt_d       = cnt_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;

      // Partial remainder is always below the divisor, so the shifted value
      // minus the divisor lies in [-dsr, dsr) and bit DATA_W is the borrow.
      shifted_c = {part_q, dvd_q[DATA_W-1]};
      diff_c    = shifted_c - {1'b0, dsr_q};
      borrow_c  = diff_c[DATA_W];

      // Negating the most negative value wraps to itself, read as unsigned 2^(W-1).
      dd_abs_c = (bus.signed_div && bus.dividend[DATA_W-1]) ? -bus.dividend : bus.dividend;
      ds_abs_c = (bus.signed_div && bus.divisor[DATA_W-1])  ? -bus.divisor  : bus.divisor;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.annul) begin
               part_d    = '0;
               dvd_d     = dd_abs_c;
               dsr_d     = ds_abs_c;
               cnt_d     = '0;
               neg_quo_d = bus.signed_div && (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
               neg_rem_d = bus.signed_div && bus.dividend[DATA_W-1];
               busy_d    = 1'b1;
               state_d   = (bus.divisor == '0) ? S_DIVZERO : S_ON;
            end
         end
         S_DIVZERO: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (!bus.annul) begin
               quotient_d  = '1;
               remainder_d = neg_rem_q ? -dvd_q : dvd_q;
               done_d      = 1'b1;
            end
         end
         S_ON: begin
            if (bus.annul) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               part_d = borrow_c ? shifted_c[DATA_W-1:0] : diff_c[DATA_W-1:0];
               dvd_d  = {dvd_q[DATA_W-2:0], ~borrow_c};
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d = S_END;
               end
            end
         end
         S_END: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (!bus.annul) begin
               quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
               remainder_d = neg_rem_q ? -part_q : part_q;
               done_d      = 1'b1;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         part_q      <= '0;
         dvd_q       <= '0;
         dsr_q       <= '0;
         cnt_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         part_q      <= part_d;
         dvd_q       <= dvd_d;
         dsr_q       <= dsr_d;
         cnt_q       <= cnt_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at start, checked at done.
module tb_div_unit;
   localparam int unsigned W = 32;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      int unsigned  lat;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   div_if #(.DATA_W(W)) bus ();

   div_unit #(.DATA_W(W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(logic [W-1:0] dd, logic [W-1:0] ds, logic sgn);
      exp_t e;
      e.lat = 33;
      if (ds == '0) begin
         e.q   = '1;
         e.r   = dd;
         e.lat = 1;
      end else if (sgn) begin
         if (dd == 32'h8000_0000 && ds == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = '0;
         end else begin
            e.q = $signed(dd) / $signed(ds);
            e.r = $signed(dd) % $signed(ds);
         end
      end else begin
         e.q = dd / ds;
         e.r = dd % ds;
      end
      return e;
   endfunction

   task automatic issue(logic [W-1:0] dd, logic [W-1:0] ds, logic sgn, bit push);
      bus.dividend   = dd;
      bus.divisor    = ds;
      bus.signed_div = sgn;
      bus.start      = 1'b1;
      if (push) sb.push_back(model(dd, ds, sgn));
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int unsigned cyc, output bit ok, output int unsigned busy_low);
      cyc = 0; ok = 1'b0; busy_low = 0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         cyc = i;
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
         if (!bus.busy) busy_low++;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      bus.start = 1'b0; bus.annul = 1'b0; bus.signed_div = 1'b0;
      bus.dividend = '0; bus.divisor = '0;
      tick(); tick();
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      total++; if (bus.quotient !== '0) begin bad++; $display("FAIL reset_quo got=%h exp=0", bus.quotient); end
      total++; if (bus.remainder !== '0) begin bad++; $display("FAIL reset_rem got=%h exp=0", bus.remainder); end
      resetn = 1'b1;
      tick();
   endtask

   // Runs a list of operations one by one and checks each against the scoreboard.
   task automatic test_ops(string name, logic [W-1:0] dds[], logic [W-1:0] dss[], logic sgns[]);
      int unsigned cyc, bl;
      bit ok;
      exp_t e;
      foreach (dds[k]) begin
         issue(dds[k], dss[k], sgns[k], 1'b1);
         total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s_busy_rise op=%0d got=%b exp=1", name, k, bus.busy); end
         wait_done(cyc, ok, bl);
         e = sb.pop_front();
         total++;
         if (!ok) begin
            bad++; $display("FAIL %s_timeout op=%0d no done within %0d cycles", name, k, cyc);
         end else begin
            total++; if (cyc !== e.lat) begin bad++; $display("FAIL %s_latency op=%0d got=%0d exp=%0d", name, k, cyc, e.lat); end
            total++; if (bus.quotient !== e.q) begin bad++; $display("FAIL %s_quo op=%0d got=%h exp=%h", name, k, bus.quotient, e.q); end
            total++; if (bus.remainder !== e.r) begin bad++; $display("FAIL %s_rem op=%0d got=%h exp=%h", name, k, bus.remainder, e.r); end
            total++; if (bl !== 0) begin bad++; $display("FAIL %s_busy_gap op=%0d got=%0d exp=0", name, k, bl); end
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_busy_at_done op=%0d got=%b exp=0", name, k, bus.busy); end
         end
         tick(); tick();
         total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse op=%0d got=%b exp=0", name, k, bus.done); end
         total++; if (bus.quotient !== e.q || bus.remainder !== e.r)
            begin bad++; $display("FAIL %s_hold op=%0d got=%h/%h exp=%h/%h", name, k, bus.quotient, bus.remainder, e.q, e.r); end
      end
   endtask

   task automatic test_unsigned();
      test_ops("unsigned", '{32'd100, 32'hFFFF_FFFF}, '{32'd7, 32'd1}, '{1'b0, 1'b0});
   endtask

   task automatic test_signed();
      test_ops("signed", '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000},
                         '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF}, '{1'b1, 1'b1, 1'b1});
   endtask

   task automatic test_divzero();
      test_ops("divzero", '{32'h1234_5678, 32'h1234_5678, 32'h8765_4321},
                          '{32'd0, 32'd0, 32'd0}, '{1'b0, 1'b1, 1'b1});
   endtask

   task automatic test_annul();
      int unsigned cyc, bl, dones;
      bit ok;
      exp_t e;
      test_ops("annul_pre", '{32'd100}, '{32'd7}, '{1'b0});
      issue(32'h1234_5678, 32'd5, 1'b0, 1'b0);
      repeat (9) tick();
      bus.annul = 1'b1;
      tick();
      bus.annul = 1'b0;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL annul_busy got=%b exp=0", bus.busy); end
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) dones++;
         tick();
      end
      total++; if (dones !== 0) begin bad++; $display("FAIL annul_no_done got=%0d exp=0", dones); end
      total++; if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2)
         begin bad++; $display("FAIL annul_outputs got=%h/%h exp=%h/%h", bus.quotient, bus.remainder, 32'd14, 32'd2); end
      issue(32'd9, 32'd3, 1'b0, 1'b1);
      wait_done(cyc, ok, bl);
      e = sb.pop_front();
      total++;
      if (!ok) begin bad++; $display("FAIL annul_after_timeout no done within %0d cycles", cyc); end
      else if (bus.quotient !== 32'd3 || bus.remainder !== 32'd0 || cyc !== e.lat)
         begin bad++; $display("FAIL annul_after got=%h/%h lat=%0d exp=%h/%h lat=%0d", bus.quotient, bus.remainder, cyc, e.q, e.r, e.lat); end
   endtask

   task automatic test_reset_mid();
      int unsigned dones;
      issue(32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0);
      repeat (19) tick();
      resetn = 1'b0;
      tick();
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
         begin bad++; $display("FAIL midreset_ctrl got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
      total++; if (bus.quotient !== '0 || bus.remainder !== '0)
         begin bad++; $display("FAIL midreset_outputs got=%h/%h exp=0/0", bus.quotient, bus.remainder); end
      resetn = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done) dones++;
      end
      total++; if (dones !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
   endtask

   task automatic test_start_busy();
      int unsigned cyc, bl;
      bit ok;
      exp_t e;
      issue(32'd100, 32'd7, 1'b0, 1'b1);
      bus.start = 1'b1; bus.dividend = 32'd55; bus.divisor = 32'd0; bus.signed_div = 1'b1;
      repeat (5) tick();
      bus.start = 1'b0;
      wait_done(cyc, ok, bl);
      cyc += 5;
      e = sb.pop_front();
      total++;
      if (!ok) begin bad++; $display("FAIL start_busy_timeout no done"); end
      else if (bus.quotient !== e.q || bus.remainder !== e.r || cyc !== e.lat || bl !== 0)
         begin bad++; $display("FAIL start_busy got=%h/%h lat=%0d gap=%0d exp=%h/%h lat=%0d", bus.quotient, bus.remainder, cyc, bl, e.q, e.r, e.lat); end
      tick();
      bus.start = 1'b1; bus.annul = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5; bus.signed_div = 1'b0;
      tick();
      bus.start = 1'b0; bus.annul = 1'b0;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_annul_busy got=%b exp=0", bus.busy); end
      bl = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done || bus.busy) bl++;
      end
      total++; if (bl !== 0) begin bad++; $display("FAIL start_annul_idle got=%0d active cycles exp=0", bl); end
   endtask

   task automatic test_back_to_back();
      int unsigned cyc, bl;
      bit ok;
      exp_t e;
      logic [W-1:0] dd, ds;
      logic sgn;
      for (int k = 0; k < 8; k++) begin
         dd  = $urandom;
         ds  = (k == 3) ? '0 : ((k % 2 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom));
         sgn = k[0];
         issue(dd, ds, sgn, 1'b1);
         total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0)
            begin bad++; $display("FAIL b2b_accept op=%0d got busy=%b done=%b exp 1/0", k, bus.busy, bus.done); end
         wait_done(cyc, ok, bl);
         e = sb.pop_front();
         total++;
         if (!ok) begin bad++; $display("FAIL b2b_timeout op=%0d no done", k); end
         else if (bus.quotient !== e.q || bus.remainder !== e.r || cyc !== e.lat)
            begin bad++; $display("FAIL b2b_result op=%0d %h/%h sgn=%b got=%h/%h lat=%0d exp=%h/%h lat=%0d",
                                  k, dd, ds, sgn, bus.quotient, bus.remainder, cyc, e.q, e.r, e.lat); end
      end
      tick();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_divzero();
      test_annul();
      test_reset_mid();
      test_start_busy();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage, directly downstream of the ALU control decoder.
- Started when the decoded ALU control is DIV_CONTROL (signed) or DIVU_CONTROL (unsigned).
- Produces quotient (written to LO) and remainder (written to HI).
- Holds the pipeline through `busy` while it iterates.

Parameters:
- DATA_W, 32, operand/result width; the iteration count equals DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request a division; sampled only in IDLE.
- annul  in  1  abort in-flight division (exception or flush).
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  in  DATA_W  rs operand; sampled with start.
- divisor  in  DATA_W  rt operand; sampled with start.
- busy  out  1  division in progress; the stall source for IF/ID/EX.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- quotient  out  DATA_W  to LO.
- remainder  out  DATA_W  to HI.

Behaviour:
- Reset: resetn=0 at a rising edge forces state IDLE and clears busy, done, quotient, remainder and all internal registers to 0. This applies in any state, including mid-division; no done is produced for an aborted operation.
- FSM states: IDLE, DIVZERO, ON, END.
- IDLE:
  - If start=1 and annul=0, latch the operands and signed_div.
  - If divisor==0, go to DIVZERO; otherwise go to ON.
  - If start=1 and annul=1 in the same cycle, annul wins and the FSM stays in IDLE.
- busy is 1 in DIVZERO, ON and END, and 0 in IDLE.
  - busy is registered: it rises on the edge that accepts start (E0).
- Operand preparation at E0, signed mode: store |dividend| and |divisor| and record the sign flags. Negating 0x80000000 yields 0x80000000, interpreted as unsigned 2^31.
- ON: one restoring step per clock for DATA_W clocks (edges E1..E32), counted by a counter.
  - Each step: shift the {partial remainder, dividend} pair left by one.
  - Trial-subtract the divisor with a DATA_W+1-bit subtraction.
  - On no borrow, keep the difference and set the quotient LSB to 1; otherwise set it to 0.
  - After the last step, go to END.
- END (edge E33):
  - Apply signs: the quotient is negated if the operand signs differed; the remainder takes the sign of the dividend.
  - Register quotient and remainder, assert done=1 for exactly one cycle, clear busy, return to IDLE.
  - Latency: start accepted at E0, done visible in the cycle after E33, i.e. 33 cycles.
- DIVZERO (edge E1): quotient = all ones, remainder = original dividend; done=1 for one cycle, busy cleared, return to IDLE. Latency is 1 cycle.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0; no trap.
- annul=1 in DIVZERO, ON or END: next edge returns to IDLE and busy=0.
  - No done is produced, and quotient/remainder keep their previous values.
- start while busy=1 is ignored; operands are not re-sampled.
- quotient and remainder are held stable between done pulses; they change only at a done edge or at reset.
- done never coincides with busy=1.
- A new start is legal in the cycle immediately after done.

Test Plan:
- Unsigned: start, signed_div=0, 100/7 → done exactly 33 cycles after acceptance, quotient=14, remainder=2; busy high for all 33 cycles.
- Signed: 0xFFFFFFF9 (−7) / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then 7/−2 → quotient=0xFFFFFFFD, remainder=1.
- Edge cases:
  - 0x80000000 / 0xFFFFFFFF signed → quotient=0x80000000, remainder=0.
  - DIVU 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
- Divide by zero: 0x12345678/0, either mode → done 1 cycle after acceptance, quotient=0xFFFFFFFF, remainder=0x12345678.
- Annul and reset mid-operation:
  - annul on iteration 10 → busy=0 next cycle, no done, outputs unchanged. A following 9/3 start then completes normally with quotient=3, remainder=0.
  - resetn=0 on iteration 20 → all outputs 0 at the next edge; no done afterwards.
- Start handling:
  - start pulses while busy → ignored; the original result is delivered.
  - start and annul both high in IDLE → stays IDLE, busy stays 0.
